rv_load_store_unit: RTL and testbench

Parametrised multicycle load/store unit between the rv32i multicycle core's execute states and a variable-latency, word-organised data memory. Handles all RV32I (and, with XLEN=64, RV64I) load/store widths with byte-lane steering, sign/zero extension, misalignment and illegal-funct3 detection, and an acknowledge timeout. One request in flight at a time; the core hands over a request with a valid/ready handshake and waits for a one-cycle response pulse.

---
 rtl/rv_load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_rv_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rv_load_store_unit
//  Description : Multicycle RV32I/RV64I load/store unit. Steers byte lanes
//                into a word-organised, variable-latency data memory, and
//                sign/zero-extends load data. Reports misaligned accesses,
//                illegal funct3 codes and memory acknowledge timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_load_store_unit #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ena,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_is_store,
    input  logic [2:0]          i_req_funct3,
    input  logic [XLEN-1:0]     i_req_addr,
    input  logic [XLEN-1:0]     i_req_wr_data,
    output logic                o_rsp_valid,
    output logic [XLEN-1:0]     o_rsp_data,
    output logic [1:0]          o_rsp_fault,
    output logic                o_mem_req,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic                o_mem_wr_ena,
    output logic [XLEN/8-1:0]   o_mem_byte_ena,
    output logic [XLEN-1:0]     o_mem_wr_data,
    input  logic [XLEN-1:0]     i_mem_rd_data,
    input  logic                i_mem_ack
);

    localparam int c_B     = XLEN / 8;
    localparam int c_OFFW  = $clog2(c_B);
    localparam int c_CNTW  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int c_LIMIT = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCESS  = 2'd1;
    localparam logic [1:0] c_ST_RESPOND = 2'd2;

    localparam logic [1:0] c_FLT_OK    = 2'b00;
    localparam logic [1:0] c_FLT_MISAL = 2'b01;
    localparam logic [1:0] c_FLT_ILLEG = 2'b10;
    localparam logic [1:0] c_FLT_TMO   = 2'b11;

    // Bit mask covering the low 1/2/4/8 bytes of a word for size code 0..3.
    function automatic logic [XLEN-1:0] f_low_mask(input logic [1:0] size);
        case (size)
            2'd0:    f_low_mask = XLEN'(8'hFF);
            2'd1:    f_low_mask = XLEN'(16'hFFFF);
            2'd2:    f_low_mask = XLEN'(32'hFFFF_FFFF);
            default: f_low_mask = '1;
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_CNTW-1:0] r_cnt;
    logic [c_OFFW-1:0] r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_store;

    logic              w_accept;
    logic              w_legal;
    logic              w_misal;
    logic [1:0]        w_fault;
    logic [c_OFFW-1:0] w_off;
    logic [c_OFFW-1:0] w_align;
    logic [1:0]        w_size;
    logic [c_B-1:0]    w_bmask;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_word_addr;
    logic [XLEN-1:0]   w_sh;
    logic [XLEN-1:0]   w_lmask;
    logic              w_sign;
    logic [XLEN-1:0]   w_ld;
    logic              w_tmo;

    // Decode the incoming request: legality, alignment and lane steering.
    always_comb begin
        w_off   = i_req_addr[c_OFFW-1:0];
        w_size  = i_req_funct3[1:0];
        w_legal = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b011:                 w_legal = (XLEN == 64);
            3'b100, 3'b101:         w_legal = ~i_req_is_store;
            3'b110:                 w_legal = ~i_req_is_store & (XLEN == 64);
            default:                w_legal = 1'b0;
        endcase
        case (w_size)
            2'd0:    begin w_align = '0;            w_bmask = c_B'(1);  end
            2'd1:    begin w_align = c_OFFW'(1);    w_bmask = c_B'(3);  end
            2'd2:    begin w_align = c_OFFW'(3);    w_bmask = c_B'(15); end
            default: begin w_align = c_OFFW'(7);    w_bmask = '1;       end
        endcase
        w_misal     = |(w_off & w_align);
        // Illegal funct3 outranks misalignment.
        w_fault     = !w_legal ? c_FLT_ILLEG : (w_misal ? c_FLT_MISAL : c_FLT_OK);
        // Store data is trimmed to its width first so unused upper bytes never
        // leak into neighbouring lanes.
        w_wdata     = (i_req_wr_data & f_low_mask(w_size)) << {w_off, 3'b000};
        w_word_addr = {i_req_addr[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
    end

    // Align the returned word to bit 0 and extend it to the full width.
    always_comb begin
        w_sh    = i_mem_rd_data >> {r_off, 3'b000};
        w_lmask = f_low_mask(r_size);
        case (r_size)
            2'd0:    w_sign = w_sh[7];
            2'd1:    w_sign = w_sh[15];
            2'd2:    w_sign = w_sh[31];
            default: w_sign = 1'b0;
        endcase
        w_ld  = (w_sh & w_lmask) | ((w_sign & ~r_unsigned) ? ~w_lmask : '0);
        // Timeout fires in the ACK_TIMEOUT-th ACCESS cycle without an ack.
        w_tmo = (ACK_TIMEOUT != 0) && (r_cnt == c_CNTW'(c_LIMIT));
    end

    // Handshake output: only the idle, enabled, non-reset unit accepts.
    always_comb begin
        o_req_ready = (r_state == c_ST_IDLE) & i_ena & ~rst;
        w_accept    = i_req_valid & o_req_ready;
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_accept) w_state_nxt = (w_fault != c_FLT_OK) ? c_ST_RESPOND : c_ST_ACCESS;
            c_ST_ACCESS:  if (i_mem_ack || w_tmo) w_state_nxt = c_ST_RESPOND;
            c_ST_RESPOND: w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Registered memory-side and response-side outputs plus request context.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rsp_valid    <= 1'b0;
            o_rsp_data     <= '0;
            o_rsp_fault    <= c_FLT_OK;
            o_mem_req      <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wr_ena   <= 1'b0;
            o_mem_byte_ena <= '0;
            o_mem_wr_data  <= '0;
            r_cnt          <= '0;
            r_off          <= '0;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_store        <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_off      <= w_off;
                        r_size     <= w_size;
                        r_unsigned <= i_req_funct3[2];
                        r_store    <= i_req_is_store;
                        r_cnt      <= '0;
                        if (w_fault != c_FLT_OK) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_fault <= w_fault;
                            o_rsp_data  <= '0;
                        end else begin
                            o_mem_req      <= 1'b1;
                            o_mem_addr     <= w_word_addr;
                            o_mem_byte_ena <= w_bmask << w_off;
                            o_mem_wr_data  <= w_wdata;
                            o_mem_wr_ena   <= i_req_is_store;
                        end
                    end
                end
                c_ST_ACCESS: begin
                    r_cnt <= r_cnt + c_CNTW'(1);
                    if (i_mem_ack || w_tmo) begin
                        o_rsp_valid    <= 1'b1;
                        o_mem_req      <= 1'b0;
                        o_mem_wr_ena   <= 1'b0;
                        o_mem_byte_ena <= '0;
                        // Ack wins when it coincides with the timeout limit.
                        o_rsp_fault    <= i_mem_ack ? c_FLT_OK : c_FLT_TMO;
                        o_rsp_data     <= (i_mem_ack && !r_store) ? w_ld : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_load_store_unit
//  Description : Directed self-checking bench for rv_load_store_unit, with
//                one XLEN=32 (ACK_TIMEOUT=4) and one XLEN=64 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        req_valid;
    logic        sel64;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wr_data;
    logic [63:0] mem_rd_data;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    logic        w_valid32, w_valid64;
    logic        ready32, rsp_valid32, mem_req32, wr_ena32;
    logic [31:0] rsp_data32, mem_addr32, wr_data32;
    logic [1:0]  fault32;
    logic [3:0]  be32;
    logic        ready64, rsp_valid64, mem_req64, wr_ena64;
    logic [63:0] rsp_data64, mem_addr64, wr_data64;
    logic [1:0]  fault64;
    logic [7:0]  be64;

    logic        w_ready, w_rsp_valid, w_mem_req, w_wr_ena;
    logic [63:0] w_rsp_data, w_mem_addr, w_wr_data, w_be;
    logic [1:0]  w_fault;

    always #5 clk = ~clk;

    assign w_valid32   = req_valid & ~sel64;
    assign w_valid64   = req_valid & sel64;
    assign w_ready     = sel64 ? ready64     : ready32;
    assign w_rsp_valid = sel64 ? rsp_valid64 : rsp_valid32;
    assign w_mem_req   = sel64 ? mem_req64   : mem_req32;
    assign w_wr_ena    = sel64 ? wr_ena64    : wr_ena32;
    assign w_rsp_data  = sel64 ? rsp_data64  : {32'h0, rsp_data32};
    assign w_mem_addr  = sel64 ? mem_addr64  : {32'h0, mem_addr32};
    assign w_wr_data   = sel64 ? wr_data64   : {32'h0, wr_data32};
    assign w_be        = sel64 ? {56'h0, be64} : {60'h0, be32};
    assign w_fault     = sel64 ? fault64     : fault32;

    rv_load_store_unit #(.XLEN(32), .ACK_TIMEOUT(4)) u_dut32 (
        .clk(clk), .rst(rst), .i_ena(ena), .i_req_valid(w_valid32),
        .o_req_ready(ready32), .i_req_is_store(req_is_store),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr[31:0]),
        .i_req_wr_data(req_wr_data[31:0]), .o_rsp_valid(rsp_valid32),
        .o_rsp_data(rsp_data32), .o_rsp_fault(fault32), .o_mem_req(mem_req32),
        .o_mem_addr(mem_addr32), .o_mem_wr_ena(wr_ena32),
        .o_mem_byte_ena(be32), .o_mem_wr_data(wr_data32),
        .i_mem_rd_data(mem_rd_data[31:0]), .i_mem_ack(mem_ack)
    );

    rv_load_store_unit #(.XLEN(64), .ACK_TIMEOUT(16)) u_dut64 (
        .clk(clk), .rst(rst), .i_ena(ena), .i_req_valid(w_valid64),
        .o_req_ready(ready64), .i_req_is_store(req_is_store),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr),
        .i_req_wr_data(req_wr_data), .o_rsp_valid(rsp_valid64),
        .o_rsp_data(rsp_data64), .o_rsp_fault(fault64), .o_mem_req(mem_req64),
        .o_mem_addr(mem_addr64), .o_mem_wr_ena(wr_ena64),
        .o_mem_byte_ena(be64), .o_mem_wr_data(wr_data64),
        .i_mem_rd_data(mem_rd_data), .i_mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transaction; called on a negedge, returns on a negedge.
    task automatic run(input bit s64, input bit st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input int dly,
                       input logic [63:0] e_addr, input logic [63:0] e_be,
                       input logic [63:0] e_wd, input logic [63:0] e_data,
                       input logic [1:0] e_flt, input string tag);
        sel64        = s64;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wr_data  = wd;
        req_valid    = 1'b1;
        #1;
        check({tag, ".ready"}, {63'h0, w_ready}, 64'h1);
        @(negedge clk);
        req_valid = 1'b0;
        if (e_flt != 2'b00) begin
            check({tag, ".rsp_valid"}, {63'h0, w_rsp_valid}, 64'h1);
            check({tag, ".fault"}, {62'h0, w_fault}, {62'h0, e_flt});
            check({tag, ".data0"}, w_rsp_data, 64'h0);
            check({tag, ".no_mem_req"}, {63'h0, w_mem_req}, 64'h0);
            @(negedge clk);
            check({tag, ".rsp_pulse"}, {63'h0, w_rsp_valid}, 64'h0);
        end else begin
            check({tag, ".mem_req"}, {63'h0, w_mem_req}, 64'h1);
            check({tag, ".mem_addr"}, w_mem_addr, e_addr);
            check({tag, ".byte_ena"}, w_be, e_be);
            check({tag, ".wr_ena"}, {63'h0, w_wr_ena}, {63'h0, st});
            if (st) check({tag, ".wr_data"}, w_wr_data, e_wd);
            repeat (dly - 1) @(negedge clk);
            mem_rd_data = rd;
            mem_ack     = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            check({tag, ".rsp_valid"}, {63'h0, w_rsp_valid}, 64'h1);
            check({tag, ".data"}, w_rsp_data, e_data);
            check({tag, ".fault"}, {62'h0, w_fault}, 2'b00);
            check({tag, ".mem_req_drop"}, {63'h0, w_mem_req}, 64'h0);
            check({tag, ".be_drop"}, w_be, 64'h0);
            @(negedge clk);
            check({tag, ".rsp_pulse"}, {63'h0, w_rsp_valid}, 64'h0);
            check({tag, ".ready_again"}, {63'h0, w_ready}, 64'h1);
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        rst = 1'b1; ena = 1'b1; req_valid = 1'b0; sel64 = 1'b0;
        req_is_store = 1'b0; req_funct3 = 3'b0; req_addr = '0;
        req_wr_data = '0; mem_rd_data = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.ready32", {63'h0, ready32}, 64'h0);
        check("rst.rsp_valid", {63'h0, rsp_valid32}, 64'h0);
        check("rst.mem_req", {63'h0, mem_req32 | mem_req64}, 64'h0);
        check("rst.rsp_data", {32'h0, rsp_data32}, 64'h0);
        check("rst.fault", {62'h0, fault64}, 64'h0);
        check("rst.be", {56'h0, be64}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // XLEN=32 loads
        run(0, 0, 3'b010, 64'h104, 0, 64'hDEADBEEF, 2, 64'h104, 64'hF, 0, 64'hDEADBEEF, 2'b00, "lw");
        run(0, 0, 3'b000, 64'h103, 0, 64'h80FF0000, 1, 64'h100, 64'h8, 0, 64'hFFFFFF80, 2'b00, "lb");
        run(0, 0, 3'b100, 64'h103, 0, 64'h80FF0000, 1, 64'h100, 64'h8, 0, 64'h00000080, 2'b00, "lbu");
        run(0, 0, 3'b101, 64'h102, 0, 64'h80FF0000, 3, 64'h100, 64'hC, 0, 64'h000080FF, 2'b00, "lhu");
        run(0, 0, 3'b001, 64'h102, 0, 64'h80FF0000, 1, 64'h100, 64'hC, 0, 64'hFFFF80FF, 2'b00, "lh");
        // ack in the same cycle the timeout limit is reached: ack wins
        run(0, 0, 3'b010, 64'h108, 0, 64'h12345678, 4, 64'h108, 64'hF, 0, 64'h12345678, 2'b00, "lw_ack_at_limit");
        // XLEN=32 stores
        run(0, 1, 3'b000, 64'h202, 64'h12345678, 0, 1, 64'h200, 64'h4, 64'h00780000, 0, 2'b00, "sb");
        run(0, 1, 3'b001, 64'h202, 64'h12345678, 0, 1, 64'h200, 64'hC, 64'h56780000, 0, 2'b00, "sh");
        run(0, 1, 3'b010, 64'h200, 64'hCAFEF00D, 0, 2, 64'h200, 64'hF, 64'hCAFEF00D, 0, 2'b00, "sw");
        // XLEN=32 faults
        run(0, 0, 3'b010, 64'h102, 0, 0, 1, 0, 0, 0, 0, 2'b01, "lw_misal");
        run(0, 1, 3'b001, 64'h203, 0, 0, 1, 0, 0, 0, 0, 2'b01, "sh_misal");
        run(0, 0, 3'b011, 64'h100, 0, 0, 1, 0, 0, 0, 0, 2'b10, "ld_on32");
        run(0, 1, 3'b100, 64'h100, 0, 0, 1, 0, 0, 0, 0, 2'b10, "st_f3_100");
        run(0, 0, 3'b111, 64'h101, 0, 0, 1, 0, 0, 0, 0, 2'b10, "illegal_over_misal");

        // Timeout on XLEN=32 (ACK_TIMEOUT=4)
        sel64 = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'h300;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid32) begin
                seen = 1'b1;
                break;
            end
            if (mem_req32) cnt++;
            @(negedge clk);
        end
        check("tmo.rsp_seen", {63'h0, seen}, 64'h1);
        check("tmo.req_cycles", 64'(cnt), 64'd4);
        check("tmo.fault", {62'h0, fault32}, 64'h3);
        check("tmo.data", {32'h0, rsp_data32}, 64'h0);
        mem_rd_data = 64'hFFFFFFFF; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("tmo.late_ack_pulse", {63'h0, rsp_valid32}, 64'h0);
        check("tmo.late_ack_fault", {62'h0, fault32}, 64'h3);
        check("tmo.late_ack_req", {63'h0, mem_req32}, 64'h0);

        // Reset in the middle of an access
        req_funct3 = 3'b010; req_addr = 64'h400; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid.mem_req", {63'h0, mem_req32}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.req_drop", {63'h0, mem_req32}, 64'h0);
        check("rstmid.no_rsp", {63'h0, rsp_valid32}, 64'h0);
        @(negedge clk);
        check("rstmid.no_rsp2", {63'h0, rsp_valid32}, 64'h0);
        check("rstmid.ready", {63'h0, ready32}, 64'h1);

        // XLEN=64
        run(1, 0, 3'b011, 64'h10, 0, 64'hFEDCBA9876543210, 2, 64'h10, 64'hFF, 0, 64'hFEDCBA9876543210, 2'b00, "ld64");
        run(1, 0, 3'b110, 64'h14, 0, 64'hFEDCBA9876543210, 1, 64'h10, 64'hF0, 0, 64'h00000000FEDCBA98, 2'b00, "lwu64");
        run(1, 0, 3'b010, 64'h14, 0, 64'hFEDCBA9876543210, 1, 64'h10, 64'hF0, 0, 64'hFFFFFFFFFEDCBA98, 2'b00, "lw64");
        run(1, 1, 3'b010, 64'h24, 64'h1122334455667788, 0, 1, 64'h20, 64'hF0, 64'h5566778800000000, 0, 2'b00, "sw64");
        run(1, 0, 3'b011, 64'h14, 0, 0, 1, 0, 0, 0, 0, 2'b01, "ld64_misal");
        run(1, 1, 3'b110, 64'h10, 0, 0, 1, 0, 0, 0, 0, 2'b10, "st64_f3_110");

        // ena low in IDLE holds off acceptance
        sel64 = 1'b1; ena = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ena0.ready", {63'h0, ready64}, 64'h0);
            @(negedge clk);
            check("ena0.no_mem_req", {63'h0, mem_req64}, 64'h0);
        end
        req_valid = 1'b0; ena = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
